// File: rtl/pll_reset_sequencer.sv
// PLL reset pulse, lock qualification and ordered release of downstream reset stages,
// with lock-loss recovery, lock-timeout retry and a bounded retry budget.
module pll_reset_sequencer #(
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 65536,
    parameter int unsigned LOCK_STABLE    = 1024,
    parameter int unsigned STAGE_GAP      = 16,
    parameter int unsigned NUM_STAGES     = 3,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic                  clk_in1,
    input  logic                  reset,
    input  logic                  locked,
    input  logic                  restart_req,
    output logic                  pll_rst,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  ready,
    output logic                  fail,
    output logic [7:0]            lock_loss_cnt,
    output logic [2:0]            state
);

    localparam int unsigned REL_CYCLES = STAGE_GAP * NUM_STAGES;
    localparam int unsigned MAX_AB     = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned MAX_CD     = (LOCK_STABLE > REL_CYCLES) ? LOCK_STABLE : REL_CYCLES;
    localparam int unsigned MAX_ALL    = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CW         = $clog2(MAX_ALL) + 1;
    localparam int unsigned AW         = $clog2(MAX_RETRIES + 1);

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4,
        S_FAIL      = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [AW-1:0]         attempt_q, attempt_d;
    logic                  pll_rst_q, pll_rst_d;
    logic [NUM_STAGES-1:0] rst_out_q, rst_out_d;
    logic                  ready_q, ready_d;
    logic                  fail_q, fail_d;
    logic [7:0]            llc_q, llc_d;
    logic                  sync1_q, locked_s;
    logic                  lost_c;

    // Two-flop synchronizer for the asynchronous lock flag.
    always_ff @(posedge clk_in1) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync1_q  <= locked;
            locked_s <= sync1_q;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk_in1) begin
        if (reset) begin
            state_q   <= S_PLL_RST;
            cnt_q     <= '0;
            attempt_q <= '0;
            pll_rst_q <= 1'b1;
            rst_out_q <= '1;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
            llc_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            attempt_q <= attempt_d;
            pll_rst_q <= pll_rst_d;
            rst_out_q <= rst_out_d;
            ready_q   <= ready_d;
            fail_q    <= fail_d;
            llc_q     <= llc_d;
        end
    end

    assign lost_c = !locked_s && (state_q == S_RELEASE || state_q == S_RUN);

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        attempt_d = attempt_q;
        pll_rst_d = pll_rst_q;
        rst_out_d = rst_out_q;
        ready_d   = ready_q;
        fail_d    = fail_q;
        llc_d     = llc_q;

        if (restart_req) begin
            state_d   = S_PLL_RST;
            pll_rst_d = 1'b1;
            rst_out_d = '1;
            ready_d   = 1'b0;
            fail_d    = 1'b0;
            if (state_q == S_FAIL) begin
                attempt_d = '0;
            end
        end else if (lost_c) begin
            state_d   = S_PLL_RST;
            pll_rst_d = 1'b1;
            rst_out_d = '1;
            ready_d   = 1'b0;
            if (llc_q != 8'hFF) begin
                llc_d = llc_q + 8'd1;
            end
        end else begin
            unique case (state_q)
                S_PLL_RST: begin
                    pll_rst_d = 1'b1;
                    rst_out_d = '1;
                    cnt_d     = cnt_q + CW'(1);
                    if (cnt_q == CW'(PLL_RST_CYCLES - 1)) begin
                        state_d   = S_WAIT_LOCK;
                        pll_rst_d = 1'b0;
                    end
                end
                S_WAIT_LOCK: begin
                    cnt_d = cnt_q + CW'(1);
                    if (locked_s) begin
                        state_d = S_STABLE;
                    end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
                        attempt_d = attempt_q + AW'(1);
                        pll_rst_d = 1'b1;
                        if (attempt_d == AW'(MAX_RETRIES)) begin
                            state_d = S_FAIL;
                            fail_d  = 1'b1;
                        end else begin
                            state_d = S_PLL_RST;
                        end
                    end
                end
                S_STABLE: begin
                    cnt_d = cnt_q + CW'(1);
                    if (!locked_s) begin
                        state_d = S_WAIT_LOCK;
                    end else if (cnt_q == CW'(LOCK_STABLE - 1)) begin
                        state_d = S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    cnt_d = cnt_q + CW'(1);
                    for (int k = 0; k < int'(NUM_STAGES); k++) begin
                        if (cnt_q == CW'(STAGE_GAP * (k + 1) - 1)) begin
                            rst_out_d[k] = 1'b0;
                        end
                    end
                    if (cnt_q == CW'(REL_CYCLES - 1)) begin
                        state_d   = S_RUN;
                        ready_d   = 1'b1;
                        attempt_d = '0;
                    end
                end
                S_RUN: begin
                end
                S_FAIL: begin
                    pll_rst_d = 1'b1;
                    rst_out_d = '1;
                    ready_d   = 1'b0;
                    fail_d    = 1'b1;
                end
                default: begin
                    state_d   = S_PLL_RST;
                    pll_rst_d = 1'b1;
                    rst_out_d = '1;
                    ready_d   = 1'b0;
                end
            endcase
        end

        // Every state change, including a forced restart, begins a fresh count.
        if (state_d != state_q || restart_req) begin
            cnt_d = '0;
        end
    end

    assign pll_rst       = pll_rst_q;
    assign rst_out       = rst_out_q;
    assign ready         = ready_q;
    assign fail          = fail_q;
    assign lock_loss_cnt = llc_q;
    assign state         = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with small timing parameters.
module tb_pll_reset_sequencer;

    logic       clk_in1 = 1'b0;
    logic       reset;
    logic       locked;
    logic       restart_req;
    logic       pll_rst;
    logic [2:0] rst_out;
    logic       ready;
    logic       fail;
    logic [7:0] lock_loss_cnt;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES(4),
        .LOCK_TIMEOUT  (20),
        .LOCK_STABLE   (8),
        .STAGE_GAP     (3),
        .NUM_STAGES    (3),
        .MAX_RETRIES   (2)
    ) dut (
        .clk_in1      (clk_in1),
        .reset        (reset),
        .locked       (locked),
        .restart_req  (restart_req),
        .pll_rst      (pll_rst),
        .rst_out      (rst_out),
        .ready        (ready),
        .fail         (fail),
        .lock_loss_cnt(lock_loss_cnt),
        .state        (state)
    );

    always #5 clk_in1 = ~clk_in1;

    initial begin
        #100000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in1);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; locked = 1'b0; restart_req = 1'b0;
        tick(2);
        total++; if (state !== 3'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", state); end
        total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL rst_pll_rst got=%b exp=1", pll_rst); end
        total++; if (rst_out !== 3'b111) begin bad++; $display("FAIL rst_rst_out got=%b exp=111", rst_out); end
        total++; if (ready !== 1'b0 || fail !== 1'b0) begin bad++; $display("FAIL rst_ready_fail got=%b%b exp=00", ready, fail); end
        total++; if (lock_loss_cnt !== 8'd0) begin bad++; $display("FAIL rst_llc got=%0d exp=0", lock_loss_cnt); end
    endtask

    task automatic test_normal_boot();
        reset = 1'b0;
        tick(3);
        total++; if (pll_rst !== 1'b1 || state !== 3'd0) begin bad++; $display("FAIL boot_pll_rst_held got=%b/%0d exp=1/0", pll_rst, state); end
        tick(1);
        total++; if (pll_rst !== 1'b0 || state !== 3'd1) begin bad++; $display("FAIL boot_pll_rst_fall got=%b/%0d exp=0/1", pll_rst, state); end
        tick(10);
        locked = 1'b1;
        tick(2);
        total++; if (state !== 3'd1) begin bad++; $display("FAIL boot_sync_latency got=%0d exp=1", state); end
        tick(1);
        total++; if (state !== 3'd2) begin bad++; $display("FAIL boot_stable_entry got=%0d exp=2", state); end
        tick(7);
        total++; if (state !== 3'd2) begin bad++; $display("FAIL boot_stable_hold got=%0d exp=2", state); end
        tick(1);
        total++; if (state !== 3'd3 || rst_out !== 3'b111) begin bad++; $display("FAIL boot_release_entry got=%0d/%b exp=3/111", state, rst_out); end
        tick(2);
        total++; if (rst_out !== 3'b111) begin bad++; $display("FAIL boot_rel_plus2 got=%b exp=111", rst_out); end
        tick(1);
        total++; if (rst_out !== 3'b110) begin bad++; $display("FAIL boot_rel_plus3 got=%b exp=110", rst_out); end
        tick(3);
        total++; if (rst_out !== 3'b100) begin bad++; $display("FAIL boot_rel_plus6 got=%b exp=100", rst_out); end
        tick(2);
        total++; if (rst_out !== 3'b100 || ready !== 1'b0) begin bad++; $display("FAIL boot_rel_plus8 got=%b/%b exp=100/0", rst_out, ready); end
        tick(1);
        total++; if (rst_out !== 3'b000 || ready !== 1'b1 || state !== 3'd4) begin bad++; $display("FAIL boot_run got=%b/%b/%0d exp=000/1/4", rst_out, ready, state); end
    endtask

    task automatic test_lock_loss_run();
        locked = 1'b0;
        tick(2);
        total++; if (ready !== 1'b1 || rst_out !== 3'b000) begin bad++; $display("FAIL loss_before got=%b/%b exp=1/000", ready, rst_out); end
        tick(1);
        total++; if (rst_out !== 3'b111 || ready !== 1'b0) begin bad++; $display("FAIL loss_outputs got=%b/%b exp=111/0", rst_out, ready); end
        total++; if (lock_loss_cnt !== 8'd1 || state !== 3'd0) begin bad++; $display("FAIL loss_cnt_state got=%0d/%0d exp=1/0", lock_loss_cnt, state); end
        locked = 1'b1;
        tick(21);
        total++; if (state !== 3'd3 || ready !== 1'b0) begin bad++; $display("FAIL relock_release got=%0d/%b exp=3/0", state, ready); end
        tick(1);
        total++; if (state !== 3'd4 || ready !== 1'b1 || lock_loss_cnt !== 8'd1) begin bad++; $display("FAIL relock_run got=%0d/%b/%0d exp=4/1/1", state, ready, lock_loss_cnt); end
    endtask

    task automatic test_loss_mid_release();
        restart_req = 1'b1;
        tick(1);
        restart_req = 1'b0;
        total++; if (state !== 3'd0 || rst_out !== 3'b111 || ready !== 1'b0) begin bad++; $display("FAIL restart_run got=%0d/%b/%b exp=0/111/0", state, rst_out, ready); end
        total++; if (lock_loss_cnt !== 8'd1) begin bad++; $display("FAIL restart_no_count got=%0d exp=1", lock_loss_cnt); end
        tick(16);
        total++; if (state !== 3'd3 || rst_out !== 3'b110) begin bad++; $display("FAIL midrel_bit0 got=%0d/%b exp=3/110", state, rst_out); end
        locked = 1'b0;
        tick(2);
        total++; if (rst_out !== 3'b110) begin bad++; $display("FAIL midrel_before got=%b exp=110", rst_out); end
        tick(1);
        total++; if (rst_out !== 3'b111 || lock_loss_cnt !== 8'd2 || state !== 3'd0) begin bad++; $display("FAIL midrel_loss got=%b/%0d/%0d exp=111/2/0", rst_out, lock_loss_cnt, state); end
        locked = 1'b1;
        tick(13);
        total++; if (state !== 3'd3) begin bad++; $display("FAIL second_release got=%0d exp=3", state); end
        locked = 1'b0;
        tick(2);
        restart_req = 1'b1;
        tick(1);
        restart_req = 1'b0;
        total++; if (state !== 3'd0 || rst_out !== 3'b111) begin bad++; $display("FAIL restart_loss got=%0d/%b exp=0/111", state, rst_out); end
        total++; if (lock_loss_cnt !== 8'd2) begin bad++; $display("FAIL restart_loss_cnt got=%0d exp=2", lock_loss_cnt); end
    endtask

    task automatic test_glitch();
        // First burn one failed attempt so a spurious attempt increment would force FAIL.
        tick(23);
        total++; if (state !== 3'd1) begin bad++; $display("FAIL glitch_pre_wait got=%0d exp=1", state); end
        tick(1);
        total++; if (state !== 3'd0 || pll_rst !== 1'b1 || fail !== 1'b0) begin bad++; $display("FAIL glitch_timeout1 got=%0d/%b/%b exp=0/1/0", state, pll_rst, fail); end
        locked = 1'b1;
        tick(5);
        total++; if (state !== 3'd2) begin bad++; $display("FAIL glitch_stable got=%0d exp=2", state); end
        tick(2);
        locked = 1'b0;
        tick(3);
        locked = 1'b1;
        total++; if (state !== 3'd1 || rst_out !== 3'b111 || fail !== 1'b0) begin bad++; $display("FAIL glitch_back got=%0d/%b/%b exp=1/111/0", state, rst_out, fail); end
        tick(2);
        total++; if (state !== 3'd1) begin bad++; $display("FAIL glitch_wait got=%0d exp=1", state); end
        tick(1);
        total++; if (state !== 3'd2) begin bad++; $display("FAIL glitch_restable got=%0d exp=2", state); end
        tick(7);
        total++; if (state !== 3'd2) begin bad++; $display("FAIL glitch_requal got=%0d exp=2", state); end
        tick(1);
        total++; if (state !== 3'd3) begin bad++; $display("FAIL glitch_release got=%0d exp=3", state); end
        tick(9);
        total++; if (state !== 3'd4 || ready !== 1'b1) begin bad++; $display("FAIL glitch_run got=%0d/%b exp=4/1", state, ready); end
    endtask

    task automatic test_timeout_fail();
        locked = 1'b0;
        restart_req = 1'b1;
        tick(1);
        restart_req = 1'b0;
        tick(3);
        total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL to_pulse1 got=%b exp=1", pll_rst); end
        tick(1);
        total++; if (pll_rst !== 1'b0 || state !== 3'd1) begin bad++; $display("FAIL to_wait1 got=%b/%0d exp=0/1", pll_rst, state); end
        tick(19);
        total++; if (pll_rst !== 1'b0 || state !== 3'd1) begin bad++; $display("FAIL to_wait1_end got=%b/%0d exp=0/1", pll_rst, state); end
        tick(1);
        total++; if (pll_rst !== 1'b1 || state !== 3'd0 || fail !== 1'b0) begin bad++; $display("FAIL to_pulse2 got=%b/%0d/%b exp=1/0/0", pll_rst, state, fail); end
        tick(3);
        total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL to_pulse2_hold got=%b exp=1", pll_rst); end
        tick(1);
        total++; if (pll_rst !== 1'b0 || state !== 3'd1) begin bad++; $display("FAIL to_wait2 got=%b/%0d exp=0/1", pll_rst, state); end
        tick(19);
        total++; if (state !== 3'd1 || fail !== 1'b0) begin bad++; $display("FAIL to_wait2_end got=%0d/%b exp=1/0", state, fail); end
        tick(1);
        total++; if (state !== 3'd5 || fail !== 1'b1 || pll_rst !== 1'b1 || rst_out !== 3'b111) begin bad++; $display("FAIL to_fail got=%0d/%b/%b/%b exp=5/1/1/111", state, fail, pll_rst, rst_out); end
        tick(5);
        total++; if (state !== 3'd5 || pll_rst !== 1'b1) begin bad++; $display("FAIL to_fail_hold got=%0d/%b exp=5/1", state, pll_rst); end
        restart_req = 1'b1;
        tick(1);
        restart_req = 1'b0;
        total++; if (state !== 3'd0 || fail !== 1'b0 || lock_loss_cnt !== 8'd2) begin bad++; $display("FAIL to_restart got=%0d/%b/%0d exp=0/0/2", state, fail, lock_loss_cnt); end
    endtask

    task automatic test_mid_reset();
        locked = 1'b1;
        tick(13);
        total++; if (state !== 3'd3) begin bad++; $display("FAIL mr_release got=%0d exp=3", state); end
        tick(4);
        total++; if (rst_out !== 3'b110) begin bad++; $display("FAIL mr_partial got=%b exp=110", rst_out); end
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        total++; if (state !== 3'd0 || pll_rst !== 1'b1 || rst_out !== 3'b111) begin bad++; $display("FAIL mr_outputs got=%0d/%b/%b exp=0/1/111", state, pll_rst, rst_out); end
        total++; if (ready !== 1'b0 || fail !== 1'b0 || lock_loss_cnt !== 8'd0) begin bad++; $display("FAIL mr_flags got=%b/%b/%0d exp=0/0/0", ready, fail, lock_loss_cnt); end
    endtask

    initial begin
        test_reset();
        test_normal_boot();
        test_lock_loss_run();
        test_loss_mid_release();
        test_glitch();
        test_timeout_fail();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Sequences the board PLL (100 MHz in; 100/400/200 MHz out) and the reset tree of the DDR3 controller design. The block runs on the free-running 100 MHz input clock. It pulses the PLL reset, qualifies the asynchronous `locked` flag for stability, and releases a configurable number of downstream reset stages in order (controller, PHY, user logic). It also detects lock loss and lock timeouts and recovers from them, giving up after a bounded number of consecutive failed lock attempts. Downstream domains re-synchronize `rst_out` bits in their own clocks.

## Interface
- `PLL_RST_CYCLES`, 16 — cycles `pll_rst` is held high per attempt (≥1).
- `LOCK_TIMEOUT`, 65536 — max cycles in WAIT_LOCK before the attempt fails.
- `LOCK_STABLE`, 1024 — consecutive synchronized-locked cycles required before release.
- `STAGE_GAP`, 16 — cycles between successive stage releases (≥1).
- `NUM_STAGES`, 3 — number of sequenced reset outputs (1..8).
- `MAX_RETRIES`, 3 — consecutive failed attempts before FAIL (≥1).
- `clk_in1` input 1 — free-running 100 MHz reference clock; all logic on rising edge.
- `reset` input 1 — synchronous, active-high block reset.
- `locked` input 1 — PLL lock flag, asynchronous; double-flop synchronized internally (`locked_s`).
- `restart_req` input 1 — single-cycle request to re-run the full sequence.
- `pll_rst` output 1 — to PLL RST.
- `rst_out` output NUM_STAGES — active-high stage resets; bit 0 is released first.
- `ready` output 1 — all stages released, PLL locked.
- `fail` output 1 — retry budget exhausted.
- `lock_loss_cnt` output 8 — saturating count of lock losses seen after release began.
- `state` output 3 — encoded FSM state: PLL_RST=0, WAIT_LOCK=1, STABLE=2, RELEASE=3, RUN=4, FAIL=5.

## Operation
- Reset values: `state`=PLL_RST, `pll_rst`=1, `rst_out`=all 1, `ready`=0, `fail`=0, `lock_loss_cnt`=0. The attempt counter, cycle counter and synchronizer flops are all 0.
- PLL_RST: `pll_rst`=1 and `rst_out`=all 1 for PLL_RST_CYCLES cycles, then go to WAIT_LOCK. The cycle counter clears on every state change.
- WAIT_LOCK: `pll_rst`=0.
  - If `locked_s`=1, go to STABLE.
  - If the counter reaches LOCK_TIMEOUT-1 with no lock, increment the attempt counter. If the new value equals MAX_RETRIES, go to FAIL; otherwise go to PLL_RST.
- STABLE:
  - If `locked_s`=0, return to WAIT_LOCK. The counter restarts; this is not a failed attempt.
  - After LOCK_STABLE consecutive cycles with `locked_s`=1, go to RELEASE.
- RELEASE: `rst_out[k]` clears STAGE_GAP·(k+1) cycles after RELEASE entry. On the cycle `rst_out[NUM_STAGES-1]` clears:
  - `ready`=1;
  - the attempt counter clears;
  - go to RUN.
- RUN: hold all outputs.
- Lock loss: `locked_s`=0 in RELEASE or RUN triggers all of the following on the next edge:
  - `rst_out`=all 1 and `ready`=0;
  - `lock_loss_cnt` increments, saturating at 255;
  - go to PLL_RST.
- `restart_req`: in any non-FAIL state, same as lock loss except `lock_loss_cnt` is not incremented. In FAIL, it clears the attempt counter and `fail`, and goes to PLL_RST.
- Priority: `reset` > `restart_req` > lock loss/timeout > normal progression.
- FAIL: `pll_rst`=1, `rst_out`=all 1, `ready`=0, `fail`=1. Exit only via `reset` or `restart_req`.
- Counter width is $clog2 of the largest of PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE and STAGE_GAP·NUM_STAGES, plus 1. No wrap is possible.

## Timing
- All outputs are registered; there is no combinational path from an input to an output.
- `locked`→`locked_s` latency: 2 cycles. The FSM reacts on the following edge, so `rst_out` reasserts 3 cycles after `locked` falls.
- `restart_req` → `rst_out` all 1 and `state`=PLL_RST: 1 cycle.
- Nominal boot after `reset` falls:
  - PLL_RST_CYCLES, then lock time + 2, then +1 into STABLE;
  - + LOCK_STABLE into RELEASE;
  - + STAGE_GAP·NUM_STAGES to `ready`.
- A `locked` glitch shorter than 1 cycle may be missed. This is acceptable; the PLL holds `locked` low for many cycles on a real loss.

## Test plan
All scenarios use PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE=8, STAGE_GAP=3, NUM_STAGES=3, MAX_RETRIES=2.

- **Normal boot.** Release `reset`, then raise `locked` 10 cycles after `pll_rst` falls.
  - `pll_rst` falls 4 cycles after reset; STABLE is entered 3 cycles after `locked` rises; RELEASE follows 8 cycles later.
  - `rst_out` bits clear at +3, +6 and +9 cycles after RELEASE entry; `ready`=1 with the last bit.
- **Timeout/fail.** Keep `locked`=0.
  - Two PLL_RST pulses occur, each 4 cycles long, separated by a 20-cycle WAIT_LOCK.
  - `fail`=1 and `state`=5 after the second timeout; `pll_rst` is held at 1.
  - `restart_req` then yields `state`=0 and `fail`=0.
- **Stability glitch.** During STABLE, drop `locked` for 3 cycles.
  - Return to WAIT_LOCK; `rst_out` stays 3'b111; attempt count is unchanged.
  - The full 8-cycle qualification repeats.
- **Lock loss in RUN.** After `ready`, drop `locked`.
  - Exactly 3 cycles later: `rst_out`=3'b111, `ready`=0, `lock_loss_cnt`=1, `state`=0.
  - Re-lock completes the sequence again.
- **Loss mid-RELEASE.** Drop `locked` after `rst_out[0]` clears.
  - All bits reassert and `lock_loss_cnt` increments.
  - Assert `restart_req` in the same cycle as a lock loss in a second run: `lock_loss_cnt` is not incremented.
- **Mid-operation reset.** Assert `reset` in RELEASE: next cycle all outputs are at their reset values.
